cpu_host_ctrl: RTL and testbench

//  Host-side sequencer for the pipelined RISC-V cpu. Accepts one command at a time over a

---
 rtl/cpu_host_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cpu_host_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_host_ctrl.sv
// Host-side command sequencer for the pipelined RISC-V core: loads imem/dmem words,
// runs the core for a cycle budget and reads back dmem words over a valid/ready channel.
module cpu_host_ctrl #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [63:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic              run_done,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              busy,
  input  logic              halt,
  input  logic              abort,
  output logic              cpu_enable,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [63:0]       wdata_ext_2,
  input  logic [63:0]       rdata_ext_2
);

  typedef enum logic [2:0] {
    StIdle, StWrI, StWrD, StRdReq, StRdWait, StRsp, StRun, StDone
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [63:0]         rsp_data_q, rsp_data_d;
  logic                run_done_q, run_done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                cpu_en_q, cpu_en_d;
  logic [ADDR_W-1:0]   addr_i_q, addr_i_d;
  logic                wen_i_q, wen_i_d;
  logic [31:0]         wdata_i_q, wdata_i_d;
  logic [ADDR_W-1:0]   addr_d_q, addr_d_d;
  logic                wen_d_q, wen_d_d;
  logic                ren_d_q, ren_d_d;
  logic [63:0]         wdata_d_q, wdata_d_d;
  logic                accept;

  assign accept = cmd_valid & cmd_ready_q;

  // All outputs are registered: each _d below is the value seen in the next state.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    run_done_d  = 1'b0;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    cpu_en_d    = 1'b0;
    addr_i_d    = addr_i_q;
    wen_i_d     = 1'b0;
    wdata_i_d   = wdata_i_q;
    addr_d_d    = addr_d_q;
    wen_d_d     = 1'b0;
    ren_d_d     = 1'b0;
    wdata_d_d   = wdata_d_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_op)
            2'd0: begin
              state_d   = StWrI;
              wen_i_d   = 1'b1;
              addr_i_d  = cmd_addr;
              wdata_i_d = cmd_wdata[31:0];
            end
            2'd1: begin
              state_d   = StWrD;
              wen_d_d   = 1'b1;
              addr_d_d  = cmd_addr;
              wdata_d_d = cmd_wdata;
            end
            2'd2: begin
              cnt_d = '0;
              rem_d = cmd_wdata[CNT_W-1:0];
              if (cmd_wdata[CNT_W-1:0] != '0) begin
                state_d  = StRun;
                cpu_en_d = 1'b1;
              end else begin
                state_d    = StDone;
                run_done_d = 1'b1;
              end
            end
            default: begin
              state_d  = StRdReq;
              ren_d_d  = 1'b1;
              addr_d_d = cmd_addr;
            end
          endcase
        end
      end
      StWrI, StWrD: state_d = StIdle;
      StRdReq:      state_d = StRdWait;
      StRdWait: begin
        // SRAM has one cycle of read latency, so data is valid during this state.
        rsp_data_d  = rdata_ext_2;
        rsp_valid_d = 1'b1;
        state_d     = StRsp;
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StRun: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1) || halt || abort) begin
          state_d    = StDone;
          run_done_d = 1'b1;
        end else begin
          cpu_en_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      run_done_q  <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      cpu_en_q    <= 1'b0;
      addr_i_q    <= '0;
      wen_i_q     <= 1'b0;
      wdata_i_q   <= '0;
      addr_d_q    <= '0;
      wen_d_q     <= 1'b0;
      ren_d_q     <= 1'b0;
      wdata_d_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      run_done_q  <= run_done_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      cpu_en_q    <= cpu_en_d;
      addr_i_q    <= addr_i_d;
      wen_i_q     <= wen_i_d;
      wdata_i_q   <= wdata_i_d;
      addr_d_q    <= addr_d_d;
      wen_d_q     <= wen_d_d;
      ren_d_q     <= ren_d_d;
      wdata_d_q   <= wdata_d_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign run_done    = run_done_q;
  assign cycle_count = cnt_q;
  assign cpu_enable  = cpu_en_q;
  assign addr_ext    = addr_i_q;
  assign wen_ext     = wen_i_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_i_q;
  assign addr_ext_2  = addr_d_q;
  assign wen_ext_2   = wen_d_q;
  assign ren_ext_2   = ren_d_q;
  assign wdata_ext_2 = wdata_d_q;

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Directed bench for cpu_host_ctrl: memory writes/reads against a small dmem model,
// budgeted runs with halt, zero budget and asynchronous reset during a run.
module tb_cpu_host_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        run_done;
  logic [31:0] cycle_count;
  logic        busy;
  logic        halt;
  logic        abort;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic [63:0] mem [0:15];

  always #5 clk = ~clk;

  cpu_host_ctrl dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .run_done(run_done), .cycle_count(cycle_count), .busy(busy),
    .halt(halt), .abort(abort), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  // Data memory model with one cycle of read latency.
  always @(posedge clk) begin
    if (wen_ext_2) mem[addr_ext_2[6:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[6:3]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    en_cnt   += int'(cpu_enable);
    done_cnt += int'(run_done);
  endtask

  // Presents one command; returns at the first cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] wd);
    chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rdata_ext_2 = '0;
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; halt = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    arst_n = 1'b1;
    tick();

    // Instruction memory write
    send(2'd0, 64'h8, 64'h0000_0000_0050_0093);
    chk("wri_wen", 64'(wen_ext), 64'd1);
    chk("wri_addr", addr_ext, 64'h8);
    chk("wri_wdata", 64'(wdata_ext), 64'h0050_0093);
    chk("wri_busy", 64'(busy), 64'd1);
    chk("wri_wen2", 64'(wen_ext_2), 64'd0);
    tick();
    chk("wri_wen_drop", 64'(wen_ext), 64'd0);
    chk("wri_ready_back", 64'(cmd_ready), 64'd1);

    // Data memory write then read back
    send(2'd1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    chk("wrd_wen2", 64'(wen_ext_2), 64'd1);
    chk("wrd_addr2", addr_ext_2, 64'h10);
    chk("wrd_wdata2", wdata_ext_2, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    chk("wrd_wen2_drop", 64'(wen_ext_2), 64'd0);
    send(2'd3, 64'h10, 64'h0);
    chk("rd_ren2", 64'(ren_ext_2), 64'd1);
    chk("rd_valid_c1", 64'(rsp_valid), 64'd0);
    tick();
    chk("rd_ren2_drop", 64'(ren_ext_2), 64'd0);
    chk("rd_valid_c2", 64'(rsp_valid), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rd_valid_held", 64'(rsp_valid), 64'd1);
      chk("rd_data", rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
      chk("rd_not_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_valid_clear", 64'(rsp_valid), 64'd0);
    chk("rd_ready_back", 64'(cmd_ready), 64'd1);

    // Run with budget 5
    en_cnt = 0; done_cnt = 0;
    send(2'd2, 64'h0, 64'd5);
    chk("run5_enable_c1", 64'(cpu_enable), 64'd1);
    chk("run5_count_c1", 64'(cycle_count), 64'd0);
    repeat (12) tick();
    chk("run5_enabled_cycles", 64'(en_cnt), 64'd5);
    chk("run5_done_pulses", 64'(done_cnt), 64'd1);
    chk("run5_cycle_count", 64'(cycle_count), 64'd5);
    chk("run5_idle", 64'(busy), 64'd0);

    // Run with budget 100, halted on the 7th enabled cycle
    en_cnt = 0; done_cnt = 0;
    send(2'd2, 64'h0, 64'd100);
    repeat (6) tick();
    chk("halt_count_c7", 64'(cycle_count), 64'd6);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_enable_off", 64'(cpu_enable), 64'd0);
    chk("halt_run_done", 64'(run_done), 64'd1);
    repeat (5) tick();
    chk("halt_enabled_cycles", 64'(en_cnt), 64'd7);
    chk("halt_done_pulses", 64'(done_cnt), 64'd1);
    chk("halt_cycle_count", 64'(cycle_count), 64'd7);

    // Zero budget
    en_cnt = 0; done_cnt = 0;
    send(2'd2, 64'h0, 64'd0);
    chk("zero_run_done", 64'(run_done), 64'd1);
    chk("zero_cycle_count", 64'(cycle_count), 64'd0);
    repeat (4) tick();
    chk("zero_enabled_cycles", 64'(en_cnt), 64'd0);
    chk("zero_done_pulses", 64'(done_cnt), 64'd1);

    // Asynchronous reset during the 3rd enabled cycle
    en_cnt = 0; done_cnt = 0;
    send(2'd2, 64'h0, 64'd10);
    tick(); tick();
    chk("arst_enable_before", 64'(cpu_enable), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("arst_enable_now", 64'(cpu_enable), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick(); tick();
    arst_n = 1'b1;
    repeat (3) tick();
    chk("arst_no_run_done", 64'(done_cnt), 64'd0);
    chk("arst_enable_stays_off", 64'(cpu_enable), 64'd0);
    chk("arst_cycle_count", 64'(cycle_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
